mips_alu: RTL and testbench

MIPS_ALU -- requirements
Module: mips_alu

---
 rtl/mips_alu_pkg.sv | 25 ++
 rtl/mips_alu_decode.sv | 49 ++++
 rtl/mips_alu.sv | 62 ++++++
 tb/tb_mips_alu.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/mips_alu_pkg.sv
// Shared constants and types for the MIPS ALU: opcode and funct field
// encodings plus the internal ALU operation enumeration.
package mips_alu_pkg;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [2:0] {
        ALU_NONE = 3'd0,
        ALU_ADD  = 3'd1,
        ALU_SUB  = 3'd2,
        ALU_AND  = 3'd3,
        ALU_OR   = 3'd4,
        ALU_SLT  = 3'd5
    } alu_op_e;

endpackage

// File: rtl/mips_alu_decode.sv
// Combinational instruction decoder: maps opcode/funct to an ALU operation,
// the register-file write enable and the illegal-instruction flag.
// Optional feature macro: MIPS_ALU_SLT_EN adds R-type SLT (funct 101010);
// without it that funct decodes as illegal.
module mips_alu_decode
    import mips_alu_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output alu_op_e    op,
    output logic       rw,
    output logic       illegal
);

    // Decode opcode first, then funct for R-type; anything unmatched is illegal
    always_comb begin
        op      = ALU_NONE;
        rw      = 1'b0;
        illegal = 1'b1;
        case (opcode)
            OPC_RTYPE: begin
                case (funct)
                    FN_ADD: begin op = ALU_ADD; rw = 1'b1; illegal = 1'b0; end
                    FN_SUB: begin op = ALU_SUB; rw = 1'b1; illegal = 1'b0; end
                    FN_AND: begin op = ALU_AND; rw = 1'b1; illegal = 1'b0; end
                    FN_OR:  begin op = ALU_OR;  rw = 1'b1; illegal = 1'b0; end
`ifdef MIPS_ALU_SLT_EN
                    FN_SLT: begin op = ALU_SLT; rw = 1'b1; illegal = 1'b0; end
`else
`endif
                    default: begin
                        op      = ALU_NONE;
                        rw      = 1'b0;
                        illegal = 1'b1;
                    end
                endcase
            end
            OPC_LW:  begin op = ALU_ADD; rw = 1'b1; illegal = 1'b0; end
            OPC_SW:  begin op = ALU_ADD; rw = 1'b0; illegal = 1'b0; end
            OPC_BEQ: begin op = ALU_SUB; rw = 1'b0; illegal = 1'b0; end
            default: begin
                op      = ALU_NONE;
                rw      = 1'b0;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mips_alu.sv
// Single-cycle-latency MIPS ALU: decodes the instruction, computes the result
// and registers result/rw/zero/illegal on every rising clock edge.
// Optional feature macro: MIPS_ALU_SLT_EN (enables SLT in mips_alu_decode).
module mips_alu
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] result,
    output logic             rw,
    output logic             zero,
    output logic             illegal
);

    alu_op_e          op;
    logic             dec_rw;
    logic             dec_illegal;
    logic [WIDTH-1:0] alu_result;

    mips_alu_decode u_decode (
        .opcode  (opcode),
        .funct   (funct),
        .op      (op),
        .rw      (dec_rw),
        .illegal (dec_illegal)
    );

    // Datapath: add/sub wrap modulo 2^WIDTH; illegal ops yield 0 so zero reads 1
    always_comb begin
        alu_result = '0;
        case (op)
            ALU_ADD: alu_result = in1 + in2;
            ALU_SUB: alu_result = in1 - in2;
            ALU_AND: alu_result = in1 & in2;
            ALU_OR:  alu_result = in1 | in2;
            ALU_SLT: alu_result = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
            default: alu_result = '0;
        endcase
    end

    // Output registers; asynchronous reset clears everything including zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result  <= '0;
            rw      <= 1'b0;
            zero    <= 1'b0;
            illegal <= 1'b0;
        end else begin
            result  <= alu_result;
            rw      <= dec_rw;
            zero    <= (alu_result == '0);
            illegal <= dec_illegal;
        end
    end

endmodule

// File: tb/tb_mips_alu.sv
// Directed self-checking bench for mips_alu. Expected values are hand-computed
// constants; SLT expectations follow MIPS_ALU_SLT_EN.
module tb_mips_alu;

    logic        clk;
    logic        rst_n;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [31:0] result;
    logic        rw;
    logic        zero;
    logic        illegal;

    int tests_run;
    int tests_failed;

    mips_alu #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .opcode  (opcode),
        .funct   (funct),
        .in1     (in1),
        .in2     (in2),
        .result  (result),
        .rw      (rw),
        .zero    (zero),
        .illegal (illegal)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one instruction at the falling edge and sample 1 ns after capture
    task automatic apply_stimulus(input logic [5:0] op, input logic [5:0] fn,
                                  input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        opcode = op;
        funct  = fn;
        in1    = a;
        in2    = b;
        @(posedge clk);
        #1;
    endtask

    // Compare all four outputs against the hand-computed expectation
    task automatic check_output(input string tag, input logic [31:0] exp_result,
                                input logic exp_rw, input logic exp_zero,
                                input logic exp_illegal);
        tests_run++;
        assert (result === exp_result && rw === exp_rw && zero === exp_zero &&
                illegal === exp_illegal)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: got result=%h rw=%b zero=%b illegal=%b, expected result=%h rw=%b zero=%b illegal=%b",
                   tag, result, rw, zero, illegal, exp_result, exp_rw, exp_zero, exp_illegal);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n  = 1'b1;
        opcode = 6'b000000;
        funct  = 6'b100000;
        in1    = 32'd0;
        in2    = 32'd0;

        #1 rst_n = 1'b0;
        #2;
        check_output("reset_state", 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        apply_stimulus(6'b000000, 6'b100000, 32'd5, 32'd7);
        check_output("add_5_7", 32'd12, 1'b1, 1'b0, 1'b0);

        apply_stimulus(6'b000100, 6'b000000, 32'h1234, 32'h1234);
        check_output("beq_equal", 32'h0, 1'b0, 1'b1, 1'b0);

        apply_stimulus(6'b000100, 6'b000000, 32'h1234, 32'h1235);
        check_output("beq_not_equal", 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);

        apply_stimulus(6'b000000, 6'b100010, 32'd10, 32'd3);
        check_output("sub_10_3", 32'd7, 1'b1, 1'b0, 1'b0);

        apply_stimulus(6'b000000, 6'b100100, 32'hFF00F0F0, 32'h0F0F0F0F);
        check_output("and", 32'h0F000000, 1'b1, 1'b0, 1'b0);

        apply_stimulus(6'b000000, 6'b100101, 32'hFF00F0F0, 32'h0F0F0F0F);
        check_output("or", 32'hFF0FFFFF, 1'b1, 1'b0, 1'b0);

        apply_stimulus(6'b100011, 6'b000000, 32'h100, 32'hFFFFFFFC);
        check_output("lw_addr", 32'hFC, 1'b1, 1'b0, 1'b0);

        apply_stimulus(6'b101011, 6'b000000, 32'h100, 32'hFFFFFFFC);
        check_output("sw_addr", 32'hFC, 1'b0, 1'b0, 1'b0);

        apply_stimulus(6'b100011, 6'b000000, 32'hFFFFFFFF, 32'h1);
        check_output("lw_wrap", 32'h0, 1'b1, 1'b1, 1'b0);

        apply_stimulus(6'b100011, 6'b100010, 32'h20, 32'h8);
        check_output("lw_funct_ignored", 32'h28, 1'b1, 1'b0, 1'b0);

        apply_stimulus(6'b000000, 6'b100000, 32'h80000000, 32'h80000000);
        check_output("add_wrap", 32'h0, 1'b1, 1'b1, 1'b0);

        apply_stimulus(6'b000010, 6'b100000, 32'h55, 32'h66);
        check_output("illegal_opcode", 32'h0, 1'b0, 1'b1, 1'b1);

        apply_stimulus(6'b000000, 6'b000000, 32'h55, 32'h66);
        check_output("illegal_funct", 32'h0, 1'b0, 1'b1, 1'b1);

`ifdef MIPS_ALU_SLT_EN
        apply_stimulus(6'b000000, 6'b101010, 32'hFFFFFFFF, 32'h1);
        check_output("slt_true", 32'h1, 1'b1, 1'b0, 1'b0);
        apply_stimulus(6'b000000, 6'b101010, 32'h1, 32'hFFFFFFFF);
        check_output("slt_false", 32'h0, 1'b1, 1'b1, 1'b0);
`else
        apply_stimulus(6'b000000, 6'b101010, 32'hFFFFFFFF, 32'h1);
        check_output("slt_disabled", 32'h0, 1'b0, 1'b1, 1'b1);
        apply_stimulus(6'b000000, 6'b101010, 32'h1, 32'hFFFFFFFF);
        check_output("slt_disabled_rev", 32'h0, 1'b0, 1'b1, 1'b1);
`endif

        // Mid-stream asynchronous reset: outputs clear before any clock edge
        apply_stimulus(6'b000000, 6'b100000, 32'd5, 32'd7);
        check_output("add_before_reset", 32'd12, 1'b1, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_output("async_reset_clear", 32'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_output("reset_held_discard", 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        apply_stimulus(6'b000000, 6'b100010, 32'd100, 32'd1);
        check_output("sub_after_reset", 32'd99, 1'b1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
